// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event collector: synchronizes level inputs, latches rising/falling
// edges as pending events and serializes them round-robin onto a valid/ready stream.
module edge_event_arbiter #(
    parameter  int CH          = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CHW         = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     sig_in,
    input  logic [2*CH-1:0]   edge_mode,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CHW-1:0]    evt_ch,
    output logic              evt_rise,
    output logic [CH-1:0]     ovf,
    input  logic              ovf_clr
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state, state_n;
    logic [CH-1:0]  sync_q [SYNC_STAGES];
    logic [CH-1:0]  s, prev_q;
    logic [CH-1:0]  rise_det, fall_det, det;
    logic [CH-1:0]  pend_q, type_q, pend_n, type_n, upd, ovf_set, grant_oh;
    logic [CHW-1:0] ptr_q, pick, cand;
    logic           found, any_pend, grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= sig_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= s;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        rise_det = '0;
        fall_det = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            rise_det[i] = s[i] & ~prev_q[i] & edge_mode[2*i];
            fall_det[i] = ~s[i] & prev_q[i] & edge_mode[2*i+1];
        end
    end

    assign det      = rise_det | fall_det;
    assign any_pend = |pend_q;

    // First pending channel after the last granted one, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= CH; k++) begin
            cand = CHW'((32'(ptr_q) + k) % CH);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign grant    = any_pend && (state == IDLE || evt_ready);
    assign grant_oh = grant ? (CH'(1) << pick) : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_pend) state_n = PRESENT;
            PRESENT: if (evt_ready && !any_pend) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A detect on the channel being granted re-arms it with the new type instead of overflowing.
    assign upd     = det & (~pend_q | grant_oh);
    assign pend_n  = (pend_q & ~grant_oh) | det;
    assign type_n  = (type_q & ~upd) | (rise_det & upd);
    assign ovf_set = det & pend_q & ~grant_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr_q    <= CHW'(CH - 1);
            pend_q   <= '0;
            type_q   <= '0;
            evt_ch   <= '0;
            evt_rise <= 1'b0;
            ovf      <= '0;
        end else begin
            state  <= state_n;
            pend_q <= pend_n;
            type_q <= type_n;
            ovf    <= (ovf & ~{CH{ovf_clr}}) | ovf_set;
            if (grant) begin
                ptr_q    <= pick;
                evt_ch   <= pick;
                evt_rise <= type_q[pick];
            end
        end
    end

    assign evt_valid = (state == PRESENT);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against an event-level reference model.
module tb_edge_event_arbiter;
    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [CH-1:0]  sig_in;
    logic [2*CH-1:0] edge_mode;
    logic           evt_valid;
    logic           evt_ready;
    logic [CHW-1:0] evt_ch;
    logic           evt_rise;
    logic [CH-1:0]  ovf;
    logic           ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.CH(CH), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .edge_mode (edge_mode),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // Reference model: input history, per-channel pending events, one presented event.
    logic [CH-1:0] hist [SS+1];
    bit  m_pend [CH];
    bit  m_rise [CH];
    bit  m_ovf  [CH];
    bit  m_busy;
    int  m_ch;
    bit  m_typ;
    int  m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= SS; k++) hist[k] = '0;
        for (int i = 0; i < CH; i++) begin
            m_pend[i] = 0;
            m_rise[i] = 0;
            m_ovf[i]  = 0;
        end
        m_busy = 0;
        m_ch   = 0;
        m_typ  = 0;
        m_ptr  = CH - 1;
    endtask

    task automatic model_step();
        logic [CH-1:0] s, p;
        int  g;
        bit  grant;
        s = hist[SS-1];
        p = hist[SS];
        g = -1;
        for (int k = 1; k <= CH; k++)
            if (g < 0 && m_pend[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
        grant = (g >= 0) && (!m_busy || evt_ready);
        if (ovf_clr) for (int i = 0; i < CH; i++) m_ovf[i] = 0;
        if (grant) begin
            m_ch      = g;
            m_typ     = m_rise[g];
            m_pend[g] = 0;
            m_ptr     = g;
            m_busy    = 1;
        end else if (m_busy && evt_ready) begin
            m_busy = 0;
        end
        for (int i = 0; i < CH; i++) begin
            bit r, f;
            r = s[i] && !p[i] && edge_mode[2*i];
            f = !s[i] && p[i] && edge_mode[2*i+1];
            if (r || f) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1;
                    m_rise[i] = r;
                end else begin
                    m_ovf[i] = 1;
                end
            end
        end
        for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sig_in;
    endtask

    function automatic logic [CH-1:0] m_ovf_vec();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic compare();
        check("valid", 32'(evt_valid), 32'(m_busy));
        if (m_busy) begin
            check("ch", 32'(evt_ch), 32'(m_ch));
            check("rise", 32'(evt_rise), 32'(m_typ));
        end
        check("ovf", 32'(ovf), 32'(m_ovf_vec()));
    endtask

    task automatic run_cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        compare();
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        model_reset();
        run_cycle();
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        sig_in    = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        async_reset();
        run_cycle();
    endtask

    initial begin
        int lat, lat_ch, nev, ev_ch, ev_rise;
        int q[$];
        int exp_rr[3];
        int rdy_pct;

        rst_n     = 1'b0;
        sig_in    = '0;
        edge_mode = 8'h55;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        @(negedge clk);
        check("init_valid", 32'(evt_valid), 32'd0);
        check("init_ch", 32'(evt_ch), 32'd0);
        check("init_rise", 32'(evt_rise), 32'd0);
        check("init_ovf", 32'(ovf), 32'd0);
        do_reset();

        // Latency: rising edge on ch2 reaches evt_valid four clocks later.
        edge_mode = 8'h55;
        evt_ready = 1'b1;
        repeat (3) run_cycle();
        sig_in[2] = 1'b1;
        lat = 0;
        lat_ch = -1;
        for (int i = 1; i <= 8; i++) begin
            run_cycle();
            if (evt_valid && lat == 0) begin
                lat = i;
                lat_ch = int'(evt_ch);
            end
        end
        check("latency", 32'(lat), 32'd4);
        check("lat_ch", 32'(lat_ch), 32'd2);

        // Falling-only channel sees exactly one event from a 5-cycle pulse.
        edge_mode = 8'h59;
        nev = 0; ev_ch = -1; ev_rise = -1;
        sig_in[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) sig_in[1] = 1'b0;
            run_cycle();
            if (evt_valid && evt_ready) begin
                nev++;
                ev_ch = int'(evt_ch);
                ev_rise = int'(evt_rise);
            end
        end
        check("fall_count", 32'(nev), 32'd1);
        check("fall_ch", 32'(ev_ch), 32'd1);
        check("fall_rise", 32'(ev_rise), 32'd0);

        // Simultaneous edges on ch0, ch1, ch3 drain round-robin back to back.
        do_reset();
        edge_mode = 8'h55;
        sig_in = 4'b1011;
        repeat (6) run_cycle();
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (evt_valid && evt_ready) q.push_back(int'(evt_ch));
            run_cycle();
        end
        exp_rr = '{0, 1, 3};
        check("rr_count", 32'(q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("rr_%0d", i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF, 32'(exp_rr[i]));

        // Overflow on ch0 (both edges) while the consumer stalls, then clear.
        do_reset();
        edge_mode = 8'h57;
        for (int e = 0; e < 3; e++) begin
            sig_in[0] = ~sig_in[0];
            repeat (6) run_cycle();
        end
        check("ovf_valid", 32'(evt_valid), 32'd1);
        check("ovf_ch", 32'(evt_ch), 32'd0);
        check("ovf_rise", 32'(evt_rise), 32'd1);
        check("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        run_cycle();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            check("hold_valid", 32'(evt_valid), 32'd1);
            check("hold_ch", 32'(evt_ch), 32'd0);
            check("hold_rise", 32'(evt_rise), 32'd1);
        end
        evt_ready = 1'b1;
        run_cycle();
        evt_ready = 1'b0;
        check("next_rise", 32'(evt_rise), 32'd0);
        repeat (3) run_cycle();

        // Reset while an event is presented and three more are pending.
        do_reset();
        edge_mode = 8'h55;
        sig_in = 4'b1111;
        repeat (6) run_cycle();
        check("pre_rst_valid", 32'(evt_valid), 32'd1);
        sig_in = '0;
        async_reset();
        evt_ready = 1'b1;
        nev = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (evt_valid) nev++;
        end
        check("stale_events", 32'(nev), 32'd0);

        // Randomized traffic with varying backpressure, modes and occasional resets.
        edge_mode = 8'($urandom());
        for (int blk = 0; blk < 6; blk++) begin
            rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < CH; i++)
                    if ($urandom_range(0, 7) == 0) sig_in[i] = ~sig_in[i];
                evt_ready = ($urandom_range(0, 99) < rdy_pct);
                ovf_clr   = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 63) == 0) edge_mode = 8'($urandom());
                if ($urandom_range(0, 399) == 0) async_reset();
                else run_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
